rcla_block_seq: RTL and testbench

RCLA_BLOCK_SEQ -- requirements
Module: rcla_block_seq

---
 rtl/rcla_block_seq_if.sv | 26 ++
 rtl/rcla_block_seq.sv | 159 +++++++++++++++
 tb/tb_rcla_block_seq.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/rcla_block_seq_if.sv
// Operand/result handshake bundle for rcla_block_seq.
// master drives operands and out_ready; slave is the adder block.
interface rcla_block_seq_if #(
    parameter int unsigned XW = 15,
    parameter int unsigned YW = 12
);
    logic          in_valid;
    logic          in_ready;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          cin;
    logic          out_valid;
    logic          out_ready;
    logic [XW:0]   s;
    logic          busy;

    modport master (
        output in_valid, x, y, cin, out_ready,
        input  in_ready, out_valid, s, busy
    );

    modport slave (
        input  in_valid, x, y, cin, out_ready,
        output in_ready, out_valid, s, busy
    );
endinterface

// File: rtl/rcla_block_seq.sv
// Sequential adder: one BW-bit carry look-ahead block per RUN cycle, low block first.
// Optional RCLA_SEQ_GPSTAT_EN adds gp_stat holding each block's {Go, Po}.
module rcla_block_seq #(
    parameter int unsigned XW = 15,
    parameter int unsigned YW = 12,
    parameter int unsigned BW = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rcla_block_seq_if.slave      bus
`ifdef RCLA_SEQ_GPSTAT_EN
    ,
    output logic [2*((XW+BW-1)/BW)-1:0] gp_stat
`endif
);
    localparam int unsigned NB = (XW + BW - 1) / BW;
    localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned PW = NB * BW;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] x_q, x_d, y_q, y_d;
    logic          carry_q, carry_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [XW:0]   s_q, s_d;
`ifdef RCLA_SEQ_GPSTAT_EN
    logic [2*NB-1:0] gp_q, gp_d;
`endif

    logic [31:0]   base;
    logic [BW-1:0] a, b, g, p, sum;
    logic [BW:0]   c;
    logic          go, po, cout;

    assign base = 32'(idx_q) * BW;
    assign a    = x_q[base +: BW];
    assign b    = y_q[base +: BW];

    // Bits past XW-1 become pure propagate so the narrow last block carries out of its top bit.
    always_comb begin
        logic term;
        logic acc;
        g = '0;
        p = '0;
        for (int i = 0; i < int'(BW); i++) begin
            if (base + 32'(i) < XW) begin
                g[i] = a[i] & b[i];
                p[i] = a[i] ^ b[i];
            end else begin
                g[i] = 1'b0;
                p[i] = 1'b1;
            end
        end
        c    = '0;
        c[0] = carry_q;
        go   = 1'b0;
        for (int i = 0; i < int'(BW); i++) begin
            acc = 1'b0;
            for (int k = 0; k <= i; k++) begin
                term = g[k];
                for (int j = k + 1; j <= i; j++) begin
                    term = term & p[j];
                end
                acc = acc | term;
            end
            if (i == int'(BW) - 1) begin
                go = acc;
            end
            term = carry_q;
            for (int j = 0; j <= i; j++) begin
                term = term & p[j];
            end
            c[i+1] = acc | term;
        end
        po   = &p;
        cout = go | (po & carry_q);
        sum  = p ^ c[BW-1:0];
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        s_d     = s_q;
`ifdef RCLA_SEQ_GPSTAT_EN
        gp_d    = gp_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    x_d     = PW'(bus.x);
                    y_d     = PW'(bus.y);
                    carry_d = bus.cin;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                for (int i = 0; i < int'(BW); i++) begin
                    if (base + 32'(i) < XW) begin
                        s_d[base+32'(i)] = sum[i];
                    end
                end
                carry_d = cout;
`ifdef RCLA_SEQ_GPSTAT_EN
                gp_d[2*idx_q +: 2] = {go, po};
`endif
                if (idx_q == IW'(NB - 1)) begin
                    s_d[XW] = cout;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            s_q     <= '0;
`ifdef RCLA_SEQ_GPSTAT_EN
            gp_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            s_q     <= s_d;
`ifdef RCLA_SEQ_GPSTAT_EN
            gp_q    <= gp_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.busy      = (state_q != StIdle);
    assign bus.s         = s_q;
`ifdef RCLA_SEQ_GPSTAT_EN
    assign gp_stat       = gp_q;
`endif

endmodule

// File: tb/tb_rcla_block_seq.sv
// Scoreboard bench for rcla_block_seq: stimulus queues expected sums, a monitor
// compares them whenever out_valid is presented.
module tb_rcla_block_seq;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rcla_block_seq_if #(.XW(15), .YW(12)) bus ();
`ifdef RCLA_SEQ_GPSTAT_EN
    logic [7:0] gp_stat;
`endif

    rcla_block_seq #(.XW(15), .YW(12), .BW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef RCLA_SEQ_GPSTAT_EN
        ,
        .gp_stat (gp_stat)
`endif
    );

    typedef struct {
        logic [15:0] s;
        logic [7:0]  gp;
        int          acc;
    } exp_t;

    exp_t q[$];
    logic prev_ov = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-block {Go, Po} over real bits only, rippled within the block.
    function automatic logic [7:0] exp_gp(input logic [14:0] x, input logic [14:0] y);
        logic [7:0] r;
        logic go, po;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            go = 1'b0;
            po = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (k * 4 + i < 15) begin
                    go = (x[k*4+i] & y[k*4+i]) | ((x[k*4+i] ^ y[k*4+i]) & go);
                    po = po & (x[k*4+i] ^ y[k*4+i]);
                end
            end
            r[2*k +: 2] = {go, po};
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got s=0x%0h, expected no result", bus.s);
            end else begin
                if (!prev_ov) check("latency", 32'(cyc - q[0].acc), 32'd4);
                check("in_ready_in_done", {31'd0, bus.in_ready}, 32'd0);
                check("sum", {16'd0, bus.s}, {16'd0, q[0].s});
`ifdef RCLA_SEQ_GPSTAT_EN
                check("gp_stat", {24'd0, gp_stat}, {24'd0, q[0].gp});
`endif
                if (bus.out_ready) void'(q.pop_front());
            end
        end
        prev_ov <= bus.out_valid;
    end

    task automatic send(input logic [14:0] x, input logic [11:0] y, input logic cin,
                        input logic [15:0] exp_s, input bit hold);
        int n = 0;
        exp_t e;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0, expected 1");
        end
        bus.in_valid = 1'b1;
        bus.x        = x;
        bus.y        = y;
        bus.cin      = cin;
        @(posedge clk);
        #1;
        e.s   = exp_s;
        e.gp  = exp_gp(x, {3'd0, y});
        e.acc = cyc;
        q.push_back(e);
        check("busy_after_accept", {31'd0, bus.busy}, 32'd1);
        if (!hold) bus.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        int n;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.x         = '0;
        bus.y         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b1;
        #12;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_s", {16'd0, bus.s}, 32'd0);
`ifdef RCLA_SEQ_GPSTAT_EN
        check("rst_gp", {24'd0, gp_stat}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        send(15'h7FFF, 12'hFFF, 1'b0, 16'h8FFE, 1'b0);
        send(15'h7FFF, 12'hFFF, 1'b1, 16'h8FFF, 1'b0);
        wait_done();

        // Stall the consumer for three cycles once the result is up.
        bus.out_ready = 1'b0;
        send(15'h1234, 12'hABC, 1'b0, 16'h1CF0, 1'b0);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("exit_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("exit_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("exit_busy", {31'd0, bus.busy}, 32'd0);
        wait_done();

        send(15'h0000, 12'h000, 1'b0, 16'h0000, 1'b0);
        wait_done();

        // Asynchronous reset while block index 2 is in flight.
        send(15'h1234, 12'hABC, 1'b1, 16'h1CF1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        q.delete();
        check("midrun_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("midrun_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("midrun_busy", {31'd0, bus.busy}, 32'd0);
        check("midrun_s", {16'd0, bus.s}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(15'h0001, 12'h001, 1'b0, 16'h0002, 1'b0);
        wait_done();

        // in_valid stays high and x/y churn while the block is busy.
        send(15'h4000, 12'h800, 1'b1, 16'h4801, 1'b1);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            bus.x = 15'($urandom);
            bus.y = 12'($urandom);
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        wait_done();

        send(15'h7FFF, 12'h000, 1'b1, 16'h8000, 1'b0);
        send(15'h5555, 12'hAAA, 1'b0, 16'h5FFF, 1'b0);
        wait_done();

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
